// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: four requesters share one 4:1 mux output channel.
// A two-state FSM grants one requester at a time and produces the mux select
// {s1,s0} and a one-hot grant. The granted lane drives a valid/ready output.
// A grant lasts for up to MAX_BEATS handshaked beats, or until the requester
// withdraws. After that, priority rotates to the next index and the arbiter
// spends one IDLE cycle before it grants again.
// Optional build macro MUX4_ARB_FIXED_PRIO_EN: the priority pointer is held
// at 0, so requester 0 has the highest priority and requester 3 the lowest.
module mux4_rr_arbiter #(
  parameter int DW        = 8,
  parameter int MAX_BEATS = 4,
  parameter int CNT_W     = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      req,
  input  logic [4*DW-1:0] d,
  output logic [3:0]      gnt,
  output logic            s0,
  output logic            s1,
  output logic            y_valid,
  output logic [DW-1:0]   y,
  input  logic            y_ready,
  output logic            y_last
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);

  state_t           state_q, state_d;
  logic [1:0]       idx_q, idx_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             pick_valid;
  logic [1:0]       pick_idx;
  logic [1:0]       cand;
  logic             xfer;
  logic             at_last;

  // Search the requests starting at ptr and wrapping round; the first set bit wins.
  always_comb begin
    // NOTE: every signal written here gets a default first. If any path left
    // one of them unassigned, the tool would infer a latch.
    pick_valid = 1'b0;
    pick_idx   = ptr_q;
    cand       = ptr_q;
    // Walk the offsets from the largest down, so the smallest offset is written last and wins.
    for (int k = 3; k >= 0; k--) begin
      cand = ptr_q + 2'(k);
      if (req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Output side of the channel. The data mux follows the held select, so y
  // shows lane {s1,s0} even while no one owns the channel.
  always_comb begin
    y = '0;
    for (int i = 0; i < 4; i++) begin
      if (idx_q == 2'(i)) y = d[i*DW +: DW];
    end
  end

  assign gnt     = gnt_q;
  assign s0      = idx_q[0];
  assign s1      = idx_q[1];
  assign y_valid = (state_q == GRANT) && req[idx_q];
  assign at_last = (cnt_q == LAST_CNT);
  assign y_last  = y_valid && at_last;
  assign xfer    = y_valid && y_ready;

  // Next state: arbitrate in IDLE; in GRANT, count beats and release the channel.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = GRANT;
          idx_d   = pick_idx;
          gnt_d   = 4'b0001 << pick_idx;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        // Release when the requester withdraws or the final beat transfers.
        // If both happen in the same cycle, this is still a single release.
        if (!req[idx_q] || (xfer && at_last)) begin
          state_d = IDLE;
          gnt_d   = '0;
          cnt_d   = '0;
          ptr_d   = idx_q + 2'd1;
        end else if (xfer) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef MUX4_ARB_FIXED_PRIO_EN
    ptr_d = '0;
`endif
  end

  // State registers with synchronous reset. A reset edge discards any beat in flight.
  always_ff @(posedge clk) begin
    // NOTE: state flops take non-blocking assignments, so every flop samples
    // values from before the edge and the order of the statements does not matter.
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      gnt_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter. It runs directed scenarios and then
// a randomized phase. Every cycle, the DUT outputs are compared with a
// transaction-level model of who owns the channel.
module tb_mux4_rr_arbiter;

  localparam int DW        = 8;
  localparam int MAX_BEATS = 4;
  localparam int CNT_W     = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      req;
  logic [4*DW-1:0] d;
  logic [3:0]      gnt;
  logic            s0, s1;
  logic            y_valid;
  logic [DW-1:0]   y;
  logic            y_ready;
  logic            y_last;

  int checks   = 0;
  int failures = 0;

  // Reference model: the current owner (-1 means idle), beats transferred in
  // this grant, the rotation pointer, and the held select.
  int m_owner = -1;
  int m_beats = 0;
  int m_ptr   = 0;
  int m_sel   = 0;

  // Grant-order capture for the all-requesting scenario.
  bit         cap_en = 1'b0;
  logic [3:0] prev_gnt = '0;
  logic [3:0] gnt_log[$];

  mux4_rr_arbiter #(.DW(DW), .MAX_BEATS(MAX_BEATS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req(req), .d(d), .gnt(gnt), .s0(s0), .s1(s1),
    .y_valid(y_valid), .y(y), .y_ready(y_ready), .y_last(y_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic check_outputs();
    logic [3:0] e_gnt;
    logic       e_valid;
    e_gnt   = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    e_valid = (m_owner >= 0) && req[m_owner];
    check("gnt",     32'(gnt),     32'(e_gnt));
    check("sel",     32'({s1, s0}), 32'(m_sel));
    check("y_valid", 32'(y_valid), 32'(e_valid));
    check("y",       32'(y),       32'(d[m_sel*DW +: DW]));
    check("y_last",  32'(y_last),  32'(e_valid && (m_beats == MAX_BEATS - 1)));
    if (cap_en && gnt !== 4'b0000 && prev_gnt === 4'b0000) gnt_log.push_back(gnt);
    prev_gnt = gnt;
  endtask

  // Advance the model by one clock from the inputs that were sampled.
  task automatic model_edge(input logic r, input logic [3:0] rq, input logic rdy);
    if (r) begin
      m_owner = -1; m_beats = 0; m_ptr = 0; m_sel = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        int i;
        i = (m_ptr + k) % 4;
        if (m_owner < 0 && rq[i]) begin
          m_owner = i; m_sel = i; m_beats = 0;
        end
      end
    end else if (!rq[m_owner] || (rdy && m_beats == MAX_BEATS - 1)) begin
`ifdef MUX4_ARB_FIXED_PRIO_EN
      m_ptr = 0;
`else
      m_ptr = (m_owner + 1) % 4;
`endif
      m_owner = -1;
      m_beats = 0;
    end else if (rdy) begin
      m_beats++;
    end
  endtask

  // One cycle: apply the inputs, check mid-cycle, take the edge, update the model.
  task automatic step(input logic r, input logic [3:0] rq, input logic rdy);
    rst = r; req = rq; y_ready = rdy;
    #3;
    check_outputs();
    @(posedge clk);
    model_edge(r, rq, rdy);
    #1;
  endtask

  task automatic do_reset();
    step(1'b1, 4'b0000, 1'b0);
    step(1'b0, 4'b0000, 1'b0);
  endtask

  initial begin
    logic [3:0] exp_order[5];
    logic [3:0] rq;
    logic       rdy;
    rst = 1'b1; req = 4'b1111; y_ready = 1'b1;
    d = {$urandom, $urandom} & {(4*DW){1'b1}};
    @(posedge clk);
    model_edge(1'b1, 4'b1111, 1'b1);
    #1;

    // Reset held with every requester active: nothing is granted, and the first grant goes to lane 0.
    step(1'b1, 4'b1111, 1'b1);
    step(1'b1, 4'b1111, 1'b1);
    check("rst_gnt", 32'(gnt), 32'h0);
    step(1'b0, 4'b1111, 1'b1);
    check("first_gnt", 32'(gnt), 32'h1);

    // A single requester on lane 2: 4 beats, one dead cycle, then a re-grant.
    do_reset();
    d = {$urandom, $urandom} & {(4*DW){1'b1}};
    for (int c = 0; c < 12; c++) step(1'b0, 4'b0100, 1'b1);
    check("single_gnt", 32'(gnt), 32'h4);

    // All lanes requesting: record the grant order.
    do_reset();
    cap_en = 1'b1;
    gnt_log.delete();
    for (int c = 0; c < 25; c++) step(1'b0, 4'b1111, 1'b1);
    cap_en = 1'b0;
`ifdef MUX4_ARB_FIXED_PRIO_EN
    exp_order = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1};
`else
    exp_order = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
`endif
    check("order_len", 32'(gnt_log.size()), 32'd5);
    for (int i = 0; i < 5 && i < gnt_log.size(); i++) check("order", 32'(gnt_log[i]), 32'(exp_order[i]));

    // Backpressure on lane 1, then the beats resume.
    do_reset();
    d = {$urandom, $urandom} & {(4*DW){1'b1}};
    step(1'b0, 4'b0010, 1'b0);
    for (int c = 0; c < 5; c++) step(1'b0, 4'b0010, 1'b0);
    check("bp_gnt", 32'(gnt), 32'h2);
    for (int c = 0; c < 5; c++) step(1'b0, 4'b0010, 1'b1);

    // Lane 3 withdraws after 2 beats; with req=1001 the next grant goes to lane 0.
    do_reset();
    step(1'b0, 4'b1000, 1'b1);
    step(1'b0, 4'b1000, 1'b1);
    step(1'b0, 4'b1000, 1'b1);
    step(1'b0, 4'b0000, 1'b1);
    step(1'b0, 4'b1001, 1'b1);
    check("wd_gnt", 32'(gnt), 32'h1);
    step(1'b0, 4'b1001, 1'b1);

    // Lanes 1 and 3 requesting continuously.
    do_reset();
    for (int c = 0; c < 30; c++) step(1'b0, 4'b1010, 1'b1);

    // Randomized phase. Requests are sticky and ready is random. Data changes
    // only on lanes that are not waiting on backpressure. Reset is applied rarely.
    rq = 4'b0000;
    rdy = 1'b0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(7) == 0) rq[i] = ~rq[i];
        if (!(rq[i] && !rdy)) d[i*DW +: DW] = DW'($urandom);
      end
      rdy = ($urandom_range(3) != 0);
      step(($urandom_range(99) == 0), rq, rdy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
